red_pitaya_mux_seq: RTL

- Parametrised successor to the fixed droplet-sensor mux sequencer.
- Steps an external analog multiplexer through any subset of NCH channels, using runtime-programmable settle and dwell times.
- Flags when the selected signal is stable, and pulses once per completed scan so the FADS sorting logic can align per-channel measurements.
- Sits between the FADS register block (mask, timing) and the DIO pins driving the mux address lines.

---
 rtl/red_pitaya_mux_seq.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/red_pitaya_mux_seq.sv
// ---------------------------------------------------------------------------
// red_pitaya_mux_seq
//
// Steps an external analog multiplexer through any subset of NCH channels.
// Each selected channel first waits settle_cycles_i cycles for the analog
// path to settle. It is then flagged stable for max(dwell_cycles_i,1)
// cycles before the sequencer moves to the next active channel. A one-cycle
// scan_done_o pulse marks the last stable cycle of the highest active
// channel, which lets downstream sorting logic align per-channel samples.
//
// Ports:
//   adc_clk_i          ADC clock
//   adc_rst_i          asynchronous, active-high reset
//   enable_i           run sequencer; low returns to IDLE
//   active_channels_i  channel mask, bit k includes channel k in the scan
//   settle_cycles_i    cycles after an address change before stable
//   dwell_cycles_i     cycles stable is held per channel (0 acts as 1)
//   mux_addr_o         selected channel index
//   signal_stable_o    high while the selected channel is settled
//   scan_done_o        one-cycle pulse at the end of each full scan
//   mux_en_o           mux enable
//
// Optional feature macro: MUX_SEQ_BREAK_BEFORE_MAKE_EN
//   When defined, mux_en_o drops for one cycle before every address change
//   (break-before-make). This adds one cycle to each channel period.
//   When undefined, mux_en_o is tied high.
// ---------------------------------------------------------------------------
module red_pitaya_mux_seq #(
   parameter int NCH = 8,
   parameter int AW  = 3,
   parameter int TW  = 16
) (
   input  logic           adc_clk_i,
   input  logic           adc_rst_i,
   input  logic           enable_i,
   input  logic [NCH-1:0] active_channels_i,
   input  logic [TW-1:0]  settle_cycles_i,
   input  logic [TW-1:0]  dwell_cycles_i,
   output logic [AW-1:0]  mux_addr_o,
   output logic           signal_stable_o,
   output logic           scan_done_o,
   output logic           mux_en_o
);

   // GAP is the break-before-make cycle; it is only reachable when the
   // optional feature is compiled in.
   typedef enum logic [1:0] {IDLE, SETTLE, DWELL, GAP} state_t;

   state_t        state;
   logic [TW-1:0] settle_cnt;
   logic [TW-1:0] dwell_cnt;

   logic          mask_nz;
   logic          cur_active;
   logic          cur_wraps;
   logic [AW-1:0] lowest_ch;
   logic [AW-1:0] next_ch;
   logic [AW-1:0] start_addr;
   logic [TW-1:0] dwell_eff;
   logic          start_done;
   logic          go_idle;
   logic          begin_switch;
   logic          apply_now;

`ifdef MUX_SEQ_BREAK_BEFORE_MAKE_EN
   logic [AW-1:0] pending_addr;
`endif

   // Lowest set bit of the mask, or 0 when the mask is empty.
   function automatic logic [AW-1:0] lowest_set(input logic [NCH-1:0] m);
      logic [AW-1:0] r;
      r = '0;
      for (int k = NCH - 1; k >= 0; k--)
         if (m[k]) r = AW'(k);
      return r;
   endfunction

   // True when some mask bit strictly above cur is set.
   function automatic logic has_above(input logic [NCH-1:0] m, input logic [AW-1:0] cur);
      logic r;
      r = 1'b0;
      for (int k = 0; k < NCH; k++)
         if (m[k] && (k > int'(cur))) r = 1'b1;
      return r;
   endfunction

   // Mask bit test that never indexes beyond NCH.
   function automatic logic bit_set(input logic [NCH-1:0] m, input logic [AW-1:0] cur);
      logic r;
      r = 1'b0;
      for (int k = 0; k < NCH; k++)
         if (m[k] && (k == int'(cur))) r = 1'b1;
      return r;
   endfunction

   // Lowest set bit strictly above cur, wrapping to the lowest set bit.
   function automatic logic [AW-1:0] next_set(input logic [NCH-1:0] m, input logic [AW-1:0] cur);
      logic [AW-1:0] r;
      logic          found;
      r     = lowest_set(m);
      found = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (!found && m[k] && (k > int'(cur))) begin
            r     = AW'(k);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // Channel selection and sequencing decisions for the current cycle. The
   // mask is looked at live, so a switch always picks its target from the
   // mask as it stands at that edge. A channel whose bit disappears aborts
   // its phase immediately.
   always_comb begin
      mask_nz    = |active_channels_i;
      cur_active = bit_set(active_channels_i, mux_addr_o);
      cur_wraps  = !has_above(active_channels_i, mux_addr_o);
      lowest_ch  = lowest_set(active_channels_i);
      next_ch    = next_set(active_channels_i, mux_addr_o);
      dwell_eff  = (dwell_cycles_i == '0) ? TW'(1) : dwell_cycles_i;
      go_idle    = !enable_i || !mask_nz;

      begin_switch = (state == IDLE) ||
                     (((state == SETTLE) || (state == DWELL)) && !cur_active) ||
                     ((state == DWELL) && (dwell_cnt == TW'(1)));

`ifdef MUX_SEQ_BREAK_BEFORE_MAKE_EN
      start_addr = pending_addr;
      apply_now  = (state == GAP);
`else
      start_addr = (state == IDLE) ? lowest_ch : next_ch;
      apply_now  = begin_switch;
`endif

      // With zero settle and single-cycle dwell, the first cycle on the new
      // channel is already its last stable cycle. The scan pulse must then
      // be raised on the same edge that applies the address.
      start_done = (settle_cycles_i == '0) && (dwell_eff == TW'(1)) &&
                   !has_above(active_channels_i, start_addr);
   end

`ifndef MUX_SEQ_BREAK_BEFORE_MAKE_EN
   assign mux_en_o = 1'b1;
`endif

   // Main sequencer. All outputs are registered here. The scan pulse is
   // raised on the edge that enters the last stable cycle, so it lines up
   // with that cycle rather than following it.
   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         state           <= IDLE;
         mux_addr_o      <= '0;
         signal_stable_o <= 1'b0;
         scan_done_o     <= 1'b0;
         settle_cnt      <= '0;
         dwell_cnt       <= '0;
`ifdef MUX_SEQ_BREAK_BEFORE_MAKE_EN
         mux_en_o        <= 1'b1;
         pending_addr    <= '0;
`endif
      end else begin
         scan_done_o <= 1'b0;
         if (go_idle) begin
            state           <= IDLE;
            signal_stable_o <= 1'b0;
`ifdef MUX_SEQ_BREAK_BEFORE_MAKE_EN
            mux_en_o        <= 1'b1;
`endif
         end else if (apply_now) begin
            mux_addr_o <= start_addr;
`ifdef MUX_SEQ_BREAK_BEFORE_MAKE_EN
            mux_en_o   <= 1'b1;
`endif
            if (settle_cycles_i == '0) begin
               state           <= DWELL;
               signal_stable_o <= 1'b1;
               dwell_cnt       <= dwell_eff;
               scan_done_o     <= start_done;
            end else begin
               state           <= SETTLE;
               signal_stable_o <= 1'b0;
               settle_cnt      <= settle_cycles_i;
            end
`ifdef MUX_SEQ_BREAK_BEFORE_MAKE_EN
         end else if (begin_switch) begin
            pending_addr    <= (state == IDLE) ? lowest_ch : next_ch;
            mux_en_o        <= 1'b0;
            signal_stable_o <= 1'b0;
            state           <= GAP;
`endif
         end else if (state == SETTLE) begin
            if (settle_cnt == TW'(1)) begin
               state           <= DWELL;
               signal_stable_o <= 1'b1;
               dwell_cnt       <= dwell_eff;
               scan_done_o     <= (dwell_eff == TW'(1)) && cur_wraps;
            end else begin
               settle_cnt <= settle_cnt - TW'(1);
            end
         end else if (state == DWELL) begin
            dwell_cnt   <= dwell_cnt - TW'(1);
            scan_done_o <= (dwell_cnt == TW'(2)) && cur_wraps;
         end
      end
   end

endmodule
